// File: rtl/shl_sequencer_pkg.sv
// Shared definitions for the multi-step shift-left sequencer:
// CCR flag masks, FSM state encoding and a CCR packing helper.
package shl_sequencer_pkg;

  localparam logic [3:0] CCR_C = 4'b1000;
  localparam logic [3:0] CCR_V = 4'b0100;
  localparam logic [3:0] CCR_N = 4'b0010;
  localparam logic [3:0] CCR_Z = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic [3:0] pack_ccr(input logic c, input logic v,
                                          input logic n, input logic z);
    return (c ? CCR_C : 4'b0) | (v ? CCR_V : 4'b0) |
           (n ? CCR_N : 4'b0) | (z ? CCR_Z : 4'b0);
  endfunction

endpackage

// File: rtl/shl_sequencer_step.sv
// shl_step: combinational one-bit shift-left with per-step C/V/N/Z flags.
// Zero latency; no flow control.
module shl_step #(
  parameter int op_size = 4
) (
  input  logic [op_size-1:0] A,
  output logic [op_size-1:0] R,
  output logic               C,
  output logic               V,
  output logic               N,
  output logic               Z
);

  always_comb begin
    R = A << 1;
    C = A[op_size-1];
    N = R[op_size-1];
    V = N ^ C;
    Z = (R == '0);
  end

endmodule

// File: rtl/shl_sequencer.sv
// shl_sequencer: computes A << count one bit per clock and builds CVNZ; busy for count+1 cycles.
// Define SHL_SEQ_STICKY_V_EN to make V the OR of every step's overflow since start.
module shl_sequencer
  import shl_sequencer_pkg::*;
#(
  parameter int op_size  = 4,
  parameter int cnt_size = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [op_size-1:0]  A,
  input  logic [cnt_size-1:0] count,
  output logic                busy,
  output logic                done,
  output logic [op_size-1:0]  R,
  output logic [3:0]          CCR
);

  state_t              state_q, state_d;
  logic [op_size-1:0]  r_q, r_d;
  logic [3:0]          ccr_q, ccr_d;
  logic [cnt_size-1:0] cnt_q, cnt_d;

  logic [op_size-1:0]  step_r;
  logic                step_c, step_v, step_n, step_z;
  logic                v_next;

  shl_step #(.op_size(op_size)) u_step (
    .A (r_q),
    .R (step_r),
    .C (step_c),
    .V (step_v),
    .N (step_n),
    .Z (step_z)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      ccr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      ccr_q   <= ccr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (count == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (cnt_q == cnt_size'(1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    r_d    = r_q;
    ccr_d  = ccr_q;
    cnt_d  = cnt_q;
`ifdef SHL_SEQ_STICKY_V_EN
    v_next = step_v | ((ccr_q & CCR_V) != 4'b0);
`else
    v_next = step_v;
`endif
    // Loading the count=0 flags at start also clears any sticky V history.
    if (state_q == ST_IDLE && start) begin
      r_d   = A;
      cnt_d = count;
      ccr_d = pack_ccr(1'b0, 1'b0, A[op_size-1], A == '0);
    end else if (state_q == ST_SHIFT) begin
      r_d   = step_r;
      cnt_d = cnt_q - cnt_size'(1);
      ccr_d = pack_ccr(step_c, v_next, step_n, step_z);
    end
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
    R    = r_q;
    CCR  = ccr_q;
  end

endmodule

// File: tb/tb_shl_sequencer.sv
// Directed bench for shl_sequencer (op_size=4, cnt_size=3): vector table plus
// hand-written mid-operation start and reset sequences.
module tb_shl_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] A;
  logic [2:0] count;
  logic       busy, done;
  logic [3:0] R;
  logic [3:0] CCR;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shl_sequencer #(.op_size(4), .cnt_size(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .count (count),
    .busy  (busy),
    .done  (done),
    .R     (R),
    .CCR   (CCR)
  );

  typedef struct {
    logic [3:0] a;
    logic [2:0] cnt;
    logic [3:0] r;
    logic [3:0] ccr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Called #1 after a clock edge; leaves off #1 after the edge that ends done.
  task automatic run_op(input string nm, input logic [3:0] a, input logic [2:0] c,
                        input logic [3:0] exp_r, input logic [3:0] exp_ccr);
    int n;
    start = 1'b1;
    A     = a;
    count = c;
    @(posedge clk); #1;
    start = 1'b0;
    A     = 4'($urandom);
    count = 3'($urandom);
    check({nm, " busy_at_k"}, {7'b0, busy}, 8'd1);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, " done_latency"}, 8'(n), {5'b0, c});
    check({nm, " R"}, {4'b0, R}, {4'b0, exp_r});
    check({nm, " CCR"}, {4'b0, CCR}, {4'b0, exp_ccr});
    @(posedge clk); #1;
    check({nm, " busy_done_drop"}, {6'b0, busy, done}, 8'd0);
    check({nm, " R_hold"}, {4'b0, R}, {4'b0, exp_r});
    check({nm, " CCR_hold"}, {4'b0, CCR}, {4'b0, exp_ccr});
  endtask

  initial begin
    int done_seen;
    int n;

    vecs[0] = '{a: 4'b0101, cnt: 3'd1, r: 4'b1010, ccr: 4'b0110};
`ifdef SHL_SEQ_STICKY_V_EN
    vecs[1] = '{a: 4'b1001, cnt: 3'd2, r: 4'b0100, ccr: 4'b0100};
    vecs[4] = '{a: 4'b1111, cnt: 3'd7, r: 4'b0000, ccr: 4'b0101};
`else
    vecs[1] = '{a: 4'b1001, cnt: 3'd2, r: 4'b0100, ccr: 4'b0000};
    vecs[4] = '{a: 4'b1111, cnt: 3'd7, r: 4'b0000, ccr: 4'b0001};
`endif
    vecs[2] = '{a: 4'b1000, cnt: 3'd1, r: 4'b0000, ccr: 4'b1101};
    vecs[3] = '{a: 4'b1100, cnt: 3'd0, r: 4'b1100, ccr: 4'b0010};
    vecs[5] = '{a: 4'b0000, cnt: 3'd0, r: 4'b0000, ccr: 4'b0001};

    rst   = 1'b1;
    start = 1'b0;
    A     = 4'b0;
    count = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy_done", {6'b0, busy, done}, 8'd0);
    check("reset R", {4'b0, R}, 8'd0);
    check("reset CCR", {4'b0, CCR}, 8'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].cnt, vecs[i].r, vecs[i].ccr);

    // Start pulsed while shifting must be ignored.
    start = 1'b1; A = 4'b0011; count = 3'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midstart R_step2", {4'b0, R}, 8'b0000_1100);
    start = 1'b1; A = 4'b1111; count = 3'd1;
    @(posedge clk); #1;
    start = 1'b0;
    check("midstart busy", {7'b0, busy}, 8'd1);
    check("midstart R_step3", {4'b0, R}, 8'b0000_1000);
    n = 3;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("midstart done_latency", 8'(n), 8'd5);
    check("midstart R", {4'b0, R}, 8'd0);
`ifdef SHL_SEQ_STICKY_V_EN
    check("midstart CCR", {4'b0, CCR}, 8'b0000_0101);
`else
    check("midstart CCR", {4'b0, CCR}, 8'b0000_0001);
`endif
    @(posedge clk); #1;
    check("midstart idle", {6'b0, busy, done}, 8'd0);

    // Reset asserted at step 3 aborts without a done pulse.
    start = 1'b1; A = 4'b0011; count = 3'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("abort R_step3", {4'b0, R}, 8'b0000_1000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy_done", {6'b0, busy, done}, 8'd0);
    check("abort R", {4'b0, R}, 8'd0);
    check("abort CCR", {4'b0, CCR}, 8'd0);
    done_seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    check("abort no_done", 8'(done_seen), 8'd0);

    run_op("after_abort", 4'b0101, 3'd1, 4'b1010, 4'b0110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shl_sequencer.md
# shl_sequencer

Multi-step shift-left controller that drives a one-bit SHL datapath step repeatedly to compute `A << count` and produce the CVNZ condition code register. It sits between the ALU operation decoder and the shift datapath. It latches an operand on a start pulse, sequences one shift per clock, and reports completion with a one-cycle `done` pulse. Results and CCR are held until the next accepted start.

## Interface

Parameters:
- `op_size`, 4, operand/result width in bits.
- `cnt_size`, 3, width of the shift-count input.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a new shift. Sampled only in IDLE.
- `A`, input, op_size: operand, latched on an accepted start.
- `count`, input, cnt_size: number of single-bit shifts, latched on an accepted start.
- `busy`, output, 1: high in SHIFT and DONE.
- `done`, output, 1: one-cycle pulse; `R`/`CCR` are final while it is high.
- `R`, output, op_size: result register.
- `CCR`, output, 4: condition codes, bit3=C, bit2=V, bit1=N, bit0=Z.

## Operation

States:
- IDLE: waiting for start.
  - `start`=1 latches `A` into `R` and `count` into the step counter.
  - If count≠0, go to SHIFT; if count=0, go to DONE.
- SHIFT: each clock performs one step:
  - `R <= R<<1`.
  - C = MSB of `R` before the shift.
  - N = MSB of the new `R`.
  - V = N^C, per step.
  - Z = (new `R` == 0).
  - Counter decrements. The step that brings it to 0 also moves to DONE.
- DONE: `done`=1 for exactly this cycle, then back to IDLE.
- count=0: `R`=`A`; CCR gets C=0, V=0, N=MSB(A), Z=(A==0).
- count ≥ op_size: shifting continues normally. `R` becomes 0, and C/V reflect the actual last step.
- `start` in SHIFT or DONE is ignored, with no queuing.
- `A` and `count` are don't-care except on an accepted start.
- After DONE, `R` and `CCR` hold their values until the next accepted start.

## Timing

- Reset: `busy`=0, `done`=0, `R`=0, `CCR`=0000, state IDLE, counter 0.
- `rst` has priority over everything. Asserting it mid-SHIFT aborts the operation; outputs are zero after that edge.
- `start` accepted at edge k: `busy`=1 from edge k.
  - Shifts occur at edges k+1 … k+count.
  - `done`=1 during the cycle after edge k+count (count=0: the cycle after edge k).
  - `busy` and `done` drop at the following edge.
- Back-to-back operation: the earliest next accepted start is the cycle after `done`.

## Configuration

- `SHL_SEQ_STICKY_V_EN` defined: V accumulates as the OR of per-step overflow since the accepted start. It is cleared at start; count=0 gives V=0.
- Not defined: V is the last step's N^C only.
- C, N and Z are unaffected by the macro.

## Structure

- Shared package holds:
  - CCR flag masks: C=4'b1000, V=4'b0100, N=4'b0010, Z=4'b0001.
  - The state encoding (IDLE/SHIFT/DONE).
- Sub-module `shl_step`: combinational one-bit shift.
  - Inputs: `A`.
  - Outputs: `R`=A<<1 and step flags C/V/N/Z.
  - The sequencer instantiates it once and registers its outputs.

## Test plan

All cases use op_size=4.

- A=0101, count=1 -> `R`=1010, `CCR`=0110; `done` high in the cycle after edge k+1.
- A=1001, count=2 -> `R`=0100, `CCR`=0000. With `SHL_SEQ_STICKY_V_EN`: `CCR`=0100.
- A=1000, count=1 -> `R`=0000, `CCR`=1101.
- A=1100, count=0 -> `R`=1100, `CCR`=0010; `done` in the cycle after edge k.
- A=1111, count=7 -> `R`=0000, `CCR`=0001; `busy` high for 8 cycles. With sticky V: `CCR`=0101.
- Mid-operation events (A=0011, count=5):
  - `start` pulsed again at step 2 with A=1111: ignored; the original result 0000 completes.
  - `rst` at step 3 instead: next edge gives `busy`=0, `R`=0, `CCR`=0, and no `done` pulse.
